cmd_word_serializer: RTL and testbench

CMD_WORD_SERIALIZER -- requirements
Module: cmd_word_serializer

---
 rtl/cmd_word_serializer.sv | 117 +++++++++++
 tb/tb_cmd_word_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_word_serializer.sv
// Buffers non-zero 22-bit controller words in a small FIFO and emits the index
// of every set bit of each word, lowest first, over a valid/ready port.
module cmd_word_serializer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] in_vec,
  input  logic        in_strobe,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic [2:0]  count,
  output logic        full,
  output logic        ovf,
  output logic        dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [21:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [21:0]     wrk, wrk_nxt;
  logic            pop, push, ovf_set, fifo_ne, word_nz;
  logic [4:0]      low_idx;
  logic            wrk_single;

  // Handshake: an index transfers on a rising edge where out_valid and
  // out_ready are both 1; out_idx/out_last stay stable while out_ready is 0.

  assign fifo_ne    = (count != 3'd0);
  assign full       = (count == 3'(DEPTH));
  assign word_nz    = (in_vec != 22'd0);
  assign wrk_single = (wrk != 22'd0) && ((wrk & (wrk - 22'd1)) == 22'd0);
  assign dbg_state  = state;

  // Scan downward so the lowest set bit is the last to win.
  always_comb begin
    low_idx = 5'd0;
    for (int i = 21; i >= 0; i--) begin
      if (wrk[i]) low_idx = 5'(i + 1);
    end
  end

  always_comb begin
    state_nxt = state;
    wrk_nxt   = wrk;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_idx   = 5'd0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_ne) begin
          pop       = 1'b1;
          wrk_nxt   = mem[rd_ptr];
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_idx   = low_idx;
        out_last  = wrk_single;
        if (out_ready) begin
          if (!wrk_single) begin
            wrk_nxt = wrk & (wrk - 22'd1);
          end else if (fifo_ne) begin
            pop     = 1'b1;
            wrk_nxt = mem[rd_ptr];
          end else begin
            wrk_nxt   = 22'd0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push    = in_strobe && word_nz && (!full || pop);
  assign ovf_set = in_strobe && word_nz && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wrk    <= 22'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      wrk   <= wrk_nxt;
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (ovf_set) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_vec;
  end

endmodule

// File: tb/tb_cmd_word_serializer.sv
// Directed bench for cmd_word_serializer: a queue-based model is compared every
// cycle, and each scenario also pins hand-computed transfer sequences.
module tb_cmd_word_serializer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] in_vec;
  logic        in_strobe;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [2:0]  count;
  logic        full;
  logic        ovf;
  logic        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  cmd_word_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_strobe(in_strobe),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .count(count), .full(full), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // behavioural model: pending words and the remaining indices of the current word
  logic [21:0] mq[$];
  logic [4:0]  cur[$];
  bit          m_busy;
  bit          m_ovf;

  task automatic load(input logic [21:0] w);
    cur.delete();
    for (int i = 0; i < 22; i++) if (w[i]) cur.push_back(5'(i + 1));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      cur.delete();
      m_busy = 0;
      m_ovf  = 0;
    end else begin
      int  sz;
      bit  popped;
      sz     = mq.size();
      popped = 0;
      if (m_busy && out_ready) begin
        void'(cur.pop_front());
        if (cur.size() == 0) begin
          if (sz > 0) begin
            load(mq.pop_front());
            popped = 1;
          end else begin
            m_busy = 0;
          end
        end
      end else if (!m_busy && sz > 0) begin
        load(mq.pop_front());
        m_busy = 1;
        popped = 1;
      end
      if (in_strobe && in_vec != 22'd0) begin
        if (sz < DEPTH || popped) mq.push_back(in_vec);
        else m_ovf = 1;
      end
    end
  end

  // compare process: every cycle, shortly after the active edge
  always @(posedge clk) begin
    #2;
    chk("cyc_valid", 32'(out_valid), 32'(m_busy));
    chk("cyc_idx",   32'(out_idx),   m_busy ? 32'(cur[0]) : 32'd0);
    chk("cyc_last",  32'(out_last),  32'(m_busy && cur.size() == 1));
    chk("cyc_count", 32'(count),     32'(mq.size()));
    chk("cyc_full",  32'(full),      32'(mq.size() == DEPTH));
    chk("cyc_ovf",   32'(ovf),       32'(m_ovf));
  end

  // transfer log, sampled with pre-edge values
  logic [5:0] obs_q[$];
  int         obs_cyc[$];
  logic [5:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back({out_idx, out_last});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_obs(input string nm);
    chk({nm, "_n"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({nm, "_xfer"}, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [21:0] v);
    in_strobe = 1'b1;
    in_vec    = v;
    @(negedge clk);
    in_strobe = 1'b0;
    in_vec    = 22'd0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((out_valid || count != 3'd0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", 32'(out_valid || count != 3'd0), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_vec    = 22'd0;
    in_strobe = 1'b0;
    out_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);

    // single word 0x000802 -> 2 then 12
    clear_obs();
    out_ready = 1'b1;
    push_word(22'h000802);
    chk("single_cnt1",  32'(count),     32'd1);
    chk("single_lat0",  32'(out_valid), 32'd0);
    step(1);
    chk("single_lat1",  32'(out_valid), 32'd1);
    chk("single_idx2",  32'(out_idx),   32'd2);
    chk("single_last0", 32'(out_last),  32'd0);
    step(1);
    chk("single_idx12", 32'(out_idx),   32'd12);
    chk("single_last1", 32'(out_last),  32'd1);
    step(1);
    chk("single_idle",  32'(out_valid), 32'd0);
    chk("single_cnt0",  32'(count),     32'd0);
    exp_q = '{{5'd2, 1'b0}, {5'd12, 1'b1}};
    check_obs("single");

    // backpressure
    clear_obs();
    out_ready = 1'b0;
    push_word(22'h000001);
    step(6);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_idx",   32'(out_idx),   32'd1);
    chk("bp_last",  32'(out_last),  32'd1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("bp_done",  32'(out_valid), 32'd0);
    exp_q = '{{5'd1, 1'b1}};
    check_obs("bp");

    // overflow: first word moves to wrk, four fill the FIFO, the sixth is dropped
    clear_obs();
    in_strobe = 1'b1;
    in_vec    = 22'h000004;
    step(5);
    chk("ovf_cnt4",  32'(count), 32'd4);
    chk("ovf_full",  32'(full),  32'd1);
    chk("ovf_clear", 32'(ovf),   32'd0);
    step(1);
    in_strobe = 1'b0;
    in_vec    = 22'd0;
    chk("ovf_set",   32'(ovf),   32'd1);
    chk("ovf_cnt4b", 32'(count), 32'd4);
    out_ready = 1'b1;
    drain(40);
    for (int i = 0; i < 5; i++) exp_q.push_back({5'd3, 1'b1});
    check_obs("ovf");
    chk("ovf_sticky", 32'(ovf),  32'd1);
    chk("ovf_nfull",  32'(full), 32'd0);
    rst = 1'b1;
    #1;
    chk("ovf_rst", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // zero word is ignored
    in_strobe = 1'b1;
    in_vec    = 22'd0;
    step(3);
    in_strobe = 1'b0;
    chk("zero_cnt",   32'(count),     32'd0);
    chk("zero_valid", 32'(out_valid), 32'd0);
    chk("zero_ovf",   32'(ovf),       32'd0);

    // back-to-back words
    clear_obs();
    out_ready = 1'b1;
    in_strobe = 1'b1;
    in_vec    = 22'h200000;
    step(1);
    in_vec    = 22'h000010;
    step(1);
    in_strobe = 1'b0;
    in_vec    = 22'd0;
    drain(20);
    exp_q = '{{5'd22, 1'b1}, {5'd5, 1'b1}};
    check_obs("b2b");
    if (obs_cyc.size() == 2) chk("b2b_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd1);

    // reset mid-emission with two words buffered
    clear_obs();
    out_ready = 1'b0;
    in_strobe = 1'b1;
    in_vec    = 22'h000802;
    step(1);
    in_vec    = 22'h000001;
    step(1);
    in_vec    = 22'h000002;
    step(1);
    in_strobe = 1'b0;
    in_vec    = 22'd0;
    chk("mid_cnt2", 32'(count),   32'd2);
    chk("mid_idx2", 32'(out_idx), 32'd2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("mid_idx12", 32'(out_idx), 32'd12);
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_idx",   32'(out_idx),   32'd0);
    chk("mid_last",  32'(out_last),  32'd0);
    chk("mid_count", 32'(count),     32'd0);
    chk("mid_full",  32'(full),      32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    step(5);
    chk("mid_quiet", 32'(out_valid), 32'd0);
    push_word(22'h000008);
    step(2);
    exp_q = '{{5'd2, 1'b0}, {5'd4, 1'b1}};
    check_obs("mid");
    drain(10);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
